// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU-to-memory sequencer: FSM states, data-op kinds and
// the request payload sent on the shared memory port.
package cpu_mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic [ADDR_W-1:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    A_REQ,
    A_WAIT,
    B_REQ,
    B_WAIT,
    DONE
  } seq_state_e;

  typedef enum logic [1:0] {
    DM_NONE,
    DM_READ,
    DM_WRITE
  } dm_op_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // Word-aligned request for either the fetch or the data access; reads carry no strobes/data
  function automatic mem_req_t make_req(input logic              is_dm,
                                        input logic [ADDR_W-1:0] im_addr,
                                        input logic [ADDR_W-1:0] dm_addr,
                                        input dm_op_e            op,
                                        input logic [STRB_W-1:0] wstrb,
                                        input logic [DATA_W-1:0] wdata);
    mem_req_t req;
    req = '0;
    if (is_dm) begin
      req.addr = dm_addr & WORD_MASK;
      if (op == DM_WRITE) begin
        req.write = 1'b1;
        req.wstrb = wstrb;
        req.wdata = wdata;
      end
    end else begin
      req.addr = im_addr & WORD_MASK;
    end
    return req;
  endfunction

endpackage

// File: rtl/mem_req_issue.sv
// Holds one outstanding memory request: fields latched on issue, valid held
// until the port accepts it.
module mem_req_issue
  import cpu_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  mem_req_t          req_in,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic              req_write,
  output logic [STRB_W-1:0] req_wstrb,
  output logic [DATA_W-1:0] req_wdata
);

  mem_req_t req_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_valid <= 1'b0;
      req_q     <= '0;
    end else if (issue) begin
      req_valid <= 1'b1;
      req_q     <= req_in;
    end else if (req_valid && req_ready) begin
      req_valid <= 1'b0;
    end
  end

  assign req_addr  = req_q.addr;
  assign req_write = req_q.write;
  assign req_wstrb = req_q.wstrb;
  assign req_wdata = req_q.wdata;

endmodule

// File: rtl/cpu_mem_sequencer.sv
// Serialises each CPU step's fetch and data access onto one request/response
// memory port, stalling the CPU until both complete.
module cpu_mem_sequencer
  import cpu_mem_pkg::*;
#(
  parameter bit          DM_FIRST = 1'b1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_im_addr,
  input  logic [ADDR_W-1:0] cpu_dm_addr,
  input  logic [DATA_W-1:0] cpu_dm_wdata,
  input  logic              cpu_dm_read,
  input  logic              cpu_dm_write,
  input  logic [STRB_W-1:0] cpu_dm_wstrb,
  output logic              stall,
  output logic [DATA_W-1:0] im_rdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_write,
  output logic [STRB_W-1:0] mem_req_wstrb,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              proto_err
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] im_addr_q, dm_addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  dm_op_e            dm_op_q;
  logic              a_is_dm_q;

  dm_op_e            cap_op_c;
  logic              cap_a_is_dm_c;
  logic              issue_c;
  mem_req_t          req_c;
  logic              in_wait_c;
  logic              rsp_done_c;
  logic              cur_is_dm_c;
  logic              proto_hit_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state, request issue, and per-cycle completion/error decode
  always_comb begin
    state_d       = state_q;
    issue_c       = 1'b0;
    req_c         = '0;
    cap_op_c      = cpu_dm_write ? DM_WRITE : (cpu_dm_read ? DM_READ : DM_NONE);
    cap_a_is_dm_c = DM_FIRST && (cap_op_c != DM_NONE);
    in_wait_c     = (state_q == A_WAIT) || (state_q == B_WAIT);
    rsp_done_c    = mem_rsp_valid && in_wait_c;
    cur_is_dm_c   = (state_q == A_WAIT) ? a_is_dm_q : !a_is_dm_q;
    proto_hit_c   = (mem_rsp_valid && !in_wait_c) ||
                    ((state_q == CAPTURE) && cpu_dm_read && cpu_dm_write);

    case (state_q)
      IDLE:    state_d = CAPTURE;
      CAPTURE: begin
        state_d = A_REQ;
        issue_c = 1'b1;
        req_c   = make_req(cap_a_is_dm_c, cpu_im_addr, cpu_dm_addr, cap_op_c,
                           cpu_dm_wstrb, cpu_dm_wdata);
      end
      A_REQ:   if (mem_req_valid && mem_req_ready) state_d = A_WAIT;
      A_WAIT: begin
        if (mem_rsp_valid) begin
          if (dm_op_q != DM_NONE) begin
            state_d = B_REQ;
            issue_c = 1'b1;
            req_c   = make_req(!a_is_dm_q, im_addr_q, dm_addr_q, dm_op_q, wstrb_q, wdata_q);
          end else begin
            state_d = DONE;
          end
        end
      end
      B_REQ:   if (mem_req_valid && mem_req_ready) state_d = B_WAIT;
      B_WAIT:  if (mem_rsp_valid) state_d = DONE;
      DONE:    state_d = CAPTURE;
      default: state_d = IDLE;
    endcase
  end

  // Capture registers, read data, stall output and status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im_addr_q <= '0;
      dm_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      dm_op_q   <= DM_NONE;
      a_is_dm_q <= 1'b0;
      stall     <= 1'b1;
      im_rdata  <= '0;
      dm_rdata  <= '0;
      stall_cnt <= '0;
      proto_err <= 1'b0;
    end else begin
      if (state_q == CAPTURE) begin
        im_addr_q <= cpu_im_addr;
        dm_addr_q <= cpu_dm_addr;
        wdata_q   <= cpu_dm_wdata;
        wstrb_q   <= cpu_dm_wstrb;
        dm_op_q   <= cap_op_c;
        a_is_dm_q <= cap_a_is_dm_c;
      end
      if (rsp_done_c) begin
        if (!cur_is_dm_c)              im_rdata <= mem_rsp_data;
        else if (dm_op_q == DM_READ)   dm_rdata <= mem_rsp_data;
      end
      stall <= (state_d != DONE);
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (proto_hit_c) proto_err <= 1'b1;
    end
  end

  mem_req_issue u_issue (
    .clk       (clk),
    .rst       (rst),
    .issue     (issue_c),
    .req_in    (req_c),
    .req_valid (mem_req_valid),
    .req_ready (mem_req_ready),
    .req_addr  (mem_req_addr),
    .req_write (mem_req_write),
    .req_wstrb (mem_req_wstrb),
    .req_wdata (mem_req_wdata)
  );

endmodule

// File: tb/tb_cpu_mem_sequencer.sv
// Bench for cpu_mem_sequencer: two instances (DM first / IM first, narrow counter)
// run the same directed CPU steps against a step-level timing and data model.
module tb_cpu_mem_sequencer;

  localparam int N_STEPS = 9;

  typedef struct {
    logic [31:0] im_addr, im_data, dm_addr, dm_data, wdata;
    logic        rd, wr;
    logic [3:0]  wstrb;
    int          hold, lat;
    logic        spur;
  } step_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cpu_im_addr = '0, cpu_dm_addr = '0, cpu_dm_wdata = '0;
  logic        cpu_dm_read = 1'b0, cpu_dm_write = 1'b0;
  logic [3:0]  cpu_dm_wstrb = '0;
  logic        mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  logic [31:0] rsp_data [2];

  logic        stall [2];
  logic [31:0] im_rdata [2], dm_rdata [2], req_addr [2], req_wdata [2];
  logic        req_valid [2], req_write [2], proto [2];
  logic [3:0]  req_wstrb [2];
  logic [31:0] cnt0;
  logic [3:0]  cnt1;

  int checks = 0, failures = 0;
  step_t steps [N_STEPS];
  int step_idx = 0, pos = 0, stall_acc = 1, cur_j = -1;
  bit started = 0, cur_wait = 0, exp_proto = 0;
  logic [31:0] exp_im = '0, exp_dm = '0;

  always #5 clk = ~clk;

  cpu_mem_sequencer #(.DM_FIRST(1'b1), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .cpu_im_addr(cpu_im_addr), .cpu_dm_addr(cpu_dm_addr),
    .cpu_dm_wdata(cpu_dm_wdata), .cpu_dm_read(cpu_dm_read), .cpu_dm_write(cpu_dm_write),
    .cpu_dm_wstrb(cpu_dm_wstrb), .stall(stall[0]), .im_rdata(im_rdata[0]), .dm_rdata(dm_rdata[0]),
    .mem_req_valid(req_valid[0]), .mem_req_ready(mem_req_ready), .mem_req_addr(req_addr[0]),
    .mem_req_write(req_write[0]), .mem_req_wstrb(req_wstrb[0]), .mem_req_wdata(req_wdata[0]),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(rsp_data[0]), .stall_cnt(cnt0), .proto_err(proto[0]));

  cpu_mem_sequencer #(.DM_FIRST(1'b0), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .cpu_im_addr(cpu_im_addr), .cpu_dm_addr(cpu_dm_addr),
    .cpu_dm_wdata(cpu_dm_wdata), .cpu_dm_read(cpu_dm_read), .cpu_dm_write(cpu_dm_write),
    .cpu_dm_wstrb(cpu_dm_wstrb), .stall(stall[1]), .im_rdata(im_rdata[1]), .dm_rdata(dm_rdata[1]),
    .mem_req_valid(req_valid[1]), .mem_req_ready(mem_req_ready), .mem_req_addr(req_addr[1]),
    .mem_req_write(req_write[1]), .mem_req_wstrb(req_wstrb[1]), .mem_req_wdata(req_wdata[1]),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(rsp_data[1]), .stall_cnt(cnt1), .proto_err(proto[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic step_t mk(input logic [31:0] im_addr, im_data, dm_addr, dm_data, wdata,
                               input logic rd, wr, input logic [3:0] wstrb,
                               input int hold, lat, input logic spur);
    step_t s;
    s.im_addr = im_addr; s.im_data = im_data; s.dm_addr = dm_addr; s.dm_data = dm_data;
    s.wdata = wdata; s.rd = rd; s.wr = wr; s.wstrb = wstrb; s.hold = hold; s.lat = lat;
    s.spur = spur;
    return s;
  endfunction

  // Step-level model: each step is CAPTURE, then per access (hold+1) REQ cycles and
  // lat WAIT cycles, then one DONE cycle; memory responds on that schedule.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("rst_stall%0d", i), 32'(stall[i]), 32'd1);
        chk($sformatf("rst_valid%0d", i), 32'(req_valid[i]), 32'd0);
        chk($sformatf("rst_im%0d", i), im_rdata[i], 32'd0);
        chk($sformatf("rst_dm%0d", i), dm_rdata[i], 32'd0);
        chk($sformatf("rst_proto%0d", i), 32'(proto[i]), 32'd0);
      end
      chk("rst_cnt0", cnt0, 32'd0);
      chk("rst_cnt1", 32'(cnt1), 32'd0);
      if (started) begin step_idx++; started = 0; end
      pos = 0; stall_acc = 1; exp_im = '0; exp_dm = '0; exp_proto = 0;
      cur_j = -1; cur_wait = 0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; rsp_data[0] = '0; rsp_data[1] = '0;
    end else if (step_idx < N_STEPS) begin
      step_t s;
      int n, per, len, j, off;
      bit in_req, in_wait, is_wr, is_rd;
      s = steps[step_idx];
      is_wr = s.wr; is_rd = s.rd && !s.wr;
      n = (s.rd || s.wr) ? 2 : 1;
      per = s.hold + 1 + s.lat;
      len = 2 + n * per;
      started = 1;
      j = 0; off = 0; in_req = 0; in_wait = 0;
      if (pos >= 1 && pos <= len - 2) begin
        j = (pos - 1) / per; off = (pos - 1) % per;
        in_req = (off <= s.hold); in_wait = !in_req;
      end
      cur_j = j; cur_wait = in_wait;
      mem_req_ready = in_req && (off == s.hold);
      mem_rsp_valid = (in_wait && off == per - 1) || (s.spur && pos == 0);
      for (int i = 0; i < 2; i++) begin
        bit is_dm;
        logic [31:0] ea, ed; logic ew; logic [3:0] es;
        is_dm = (n == 2) && ((j == 0) == (i == 0));
        ea = (is_dm ? s.dm_addr : s.im_addr) & 32'hFFFF_FFFC;
        ew = is_dm && is_wr;
        es = ew ? s.wstrb : 4'd0;
        ed = ew ? s.wdata : 32'd0;
        chk($sformatf("stall%0d_s%0d_p%0d", i, step_idx, pos), 32'(stall[i]), 32'(pos != len - 1));
        chk($sformatf("valid%0d_s%0d_p%0d", i, step_idx, pos), 32'(req_valid[i]), 32'(in_req));
        if (in_req) begin
          chk($sformatf("addr%0d_s%0d_p%0d", i, step_idx, pos), req_addr[i], ea);
          chk($sformatf("write%0d_s%0d_p%0d", i, step_idx, pos), 32'(req_write[i]), 32'(ew));
          chk($sformatf("wstrb%0d_s%0d_p%0d", i, step_idx, pos), 32'(req_wstrb[i]), 32'(es));
          chk($sformatf("wdata%0d_s%0d_p%0d", i, step_idx, pos), req_wdata[i], ed);
        end
        if (s.spur && pos == 0) rsp_data[i] = 32'hFFFF_FFFF;
        else if (in_wait)       rsp_data[i] = !is_dm ? s.im_data : (is_wr ? 32'hBAD0_BAD0 : s.dm_data);
        else                    rsp_data[i] = '0;
      end
      if (pos == 0 && (s.spur || (s.rd && s.wr))) exp_proto = 1;
      if (pos == len - 1) begin
        exp_im = s.im_data;
        if (is_rd) exp_dm = s.dm_data;
        stall_acc += len - 1;
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("im%0d_s%0d", i, step_idx), im_rdata[i], exp_im);
          chk($sformatf("dm%0d_s%0d", i, step_idx), dm_rdata[i], exp_dm);
          chk($sformatf("proto%0d_s%0d", i, step_idx), 32'(proto[i]), 32'(exp_proto));
        end
        chk($sformatf("cnt0_s%0d", step_idx), cnt0, 32'(stall_acc));
        chk($sformatf("cnt1_s%0d", step_idx), 32'(cnt1), 32'(stall_acc > 15 ? 15 : stall_acc));
        step_idx++; started = 0; pos = 0;
      end else begin
        pos++;
      end
    end
    if (step_idx < N_STEPS) begin
      cpu_im_addr  = steps[step_idx].im_addr;
      cpu_dm_addr  = steps[step_idx].dm_addr;
      cpu_dm_wdata = steps[step_idx].wdata;
      cpu_dm_read  = steps[step_idx].rd;
      cpu_dm_write = steps[step_idx].wr;
      cpu_dm_wstrb = steps[step_idx].wstrb;
    end
  end

  task automatic wait_step(input int k);
    int n = 0;
    while (step_idx < k && n < 2000) begin
      @(negedge clk); #3; n++;
    end
    if (step_idx < k) begin
      checks++; failures++;
      $display("FAIL wait_step%0d: timed out at step %0d", k, step_idx);
    end
  endtask

  initial begin
    int n;
    steps[0] = mk(32'h0000_0102, 32'h0000_0013, 32'h0, 32'h0, 32'h0, 0, 0, 4'h0, 0, 1, 0);
    steps[1] = mk(32'h0000_0104, 32'h0000_0013, 32'h0, 32'h0, 32'h0, 0, 0, 4'h0, 0, 1, 0);
    steps[2] = mk(32'h0000_0108, 32'h00A0_0093, 32'h1006, 32'hDEAD_BEEF, 32'h0, 1, 0, 4'h0, 0, 1, 0);
    steps[3] = mk(32'h0000_010C, 32'h0000_0093, 32'h2000, 32'h0, 32'h1234_ABCD, 0, 1, 4'b0011, 5, 1, 0);
    steps[4] = mk(32'h0000_0110, 32'h0010_0073, 32'h3001, 32'h0BAD_F00D, 32'hCAFE_F00D, 1, 1, 4'b1111, 0, 2, 1);
    steps[5] = mk(32'h0000_0114, 32'h0020_0093, 32'h0, 32'h0, 32'h0, 0, 0, 4'h0, 0, 1, 0);
    steps[6] = mk(32'h0000_0200, 32'h0000_0013, 32'h4000, 32'h7777_7777, 32'h0, 1, 0, 4'h0, 0, 4, 0);
    steps[7] = mk(32'h0000_8000, 32'h0030_0093, 32'h0, 32'h0, 32'h0, 0, 0, 4'h0, 0, 1, 0);
    steps[8] = mk(32'h0000_8004, 32'h0040_0093, 32'h5008, 32'h55AA_55AA, 32'h0, 1, 0, 4'h0, 1, 2, 0);
    rsp_data[0] = '0; rsp_data[1] = '0;

    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    wait_step(1);
    chk("lit_im0_fetch", im_rdata[0], 32'h0000_0013);
    chk("lit_im1_fetch", im_rdata[1], 32'h0000_0013);
    chk("lit_cnt0_first", cnt0, 32'd4);
    wait_step(2);
    chk("lit_cnt0_second", cnt0, 32'd7);
    wait_step(3);
    chk("lit_dm0_load", dm_rdata[0], 32'hDEAD_BEEF);
    chk("lit_im0_load", im_rdata[0], 32'h00A0_0093);
    chk("lit_dm1_load", dm_rdata[1], 32'hDEAD_BEEF);
    chk("lit_im1_load", im_rdata[1], 32'h00A0_0093);
    chk("lit_cnt0_load", cnt0, 32'd12);
    wait_step(4);
    chk("lit_dm0_store", dm_rdata[0], 32'hDEAD_BEEF);
    chk("lit_cnt0_store", cnt0, 32'd27);
    chk("lit_cnt1_sat", 32'(cnt1), 32'd15);
    wait_step(5);
    chk("lit_proto0", 32'(proto[0]), 32'd1);
    chk("lit_proto1", 32'(proto[1]), 32'd1);
    chk("lit_im0_spur", im_rdata[0], 32'h0010_0073);
    wait_step(6);
    chk("lit_proto0_sticky", 32'(proto[0]), 32'd1);

    // reset in the middle of the second access's response wait
    n = 0;
    while (!(step_idx == 6 && cur_j == 1 && cur_wait) && n < 2000) begin
      @(negedge clk); #3; n++;
    end
    if (n >= 2000) begin
      checks++; failures++;
      $display("FAIL mid_reset_wait: B wait never reached, step %0d", step_idx);
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("midrst_valid%0d", i), 32'(req_valid[i]), 32'd0);
      chk($sformatf("midrst_stall%0d", i), 32'(stall[i]), 32'd1);
    end
    chk("midrst_cnt0", cnt0, 32'd0);
    chk("midrst_cnt1", 32'(cnt1), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    wait_step(8);
    chk("lit_im0_restart", im_rdata[0], 32'h0030_0093);
    chk("lit_dm0_restart", dm_rdata[0], 32'h0);
    chk("lit_proto0_cleared", 32'(proto[0]), 32'd0);
    chk("lit_cnt0_restart", cnt0, 32'd4);
    wait_step(9);
    chk("lit_dm0_last", dm_rdata[0], 32'h55AA_55AA);
    chk("lit_dm1_last", dm_rdata[1], 32'h55AA_55AA);
    chk("lit_cnt0_last", cnt0, 32'd13);
    chk("lit_cnt1_last", 32'(cnt1), 32'd13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_mem_sequencer.md
Name: cpu_mem_sequencer

Overview:
- Sits between `cpu` and the single shared memory port, replacing direct IM/DM wiring.
- Each CPU step, it captures the instruction-fetch address and any data-memory access. It issues them one at a time on a request/response port with variable latency.
- It holds `stall` high until both accesses finish, then releases the CPU for exactly one cycle with fetch data and load data valid.
- Also keeps a stall-cycle performance counter and a sticky protocol-error flag.

Parameters:
- DM_FIRST, 1, 1 = DM access before IM fetch in each step (DM belongs to the older instruction); 0 = IM first.
- CNT_W, 32, width of stall performance counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cpu_im_addr  in  32  fetch address (IM_address)
- cpu_dm_addr  in  32  data address (ALU_result_MEM)
- cpu_dm_wdata  in  32  store data (DM_input)
- cpu_dm_read  in  1  load in MEM stage
- cpu_dm_write  in  1  store in MEM stage
- cpu_dm_wstrb  in  4  byte strobes, already decoded from opcode/funct3
- stall  out  1  CPU-wide stall
- im_rdata  out  32  fetched instruction (IM_Instruction)
- dm_rdata  out  32  load data (DM_data)
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  request accepted
- mem_req_addr  out  32  word-aligned address
- mem_req_write  out  1  1 = write
- mem_req_wstrb  out  4  write strobes (0 on reads)
- mem_req_wdata  out  32  write data
- mem_rsp_valid  in  1  response / write-ack valid
- mem_rsp_data  in  32  read data
- stall_cnt  out  CNT_W  stall-high cycles since reset, saturating
- proto_err  out  1  sticky protocol error

Behaviour:
Reset (rst low, asynchronous):
- Outputs: stall=1, mem_req_valid=0, im_rdata=0, dm_rdata=0, stall_cnt=0, proto_err=0.
- Internal: capture registers=0, state=IDLE.
- Reset mid-transaction aborts the access with no completion; mem_req_valid drops immediately.

Control FSM:
- States: IDLE, CAPTURE, A_REQ, A_WAIT, B_REQ, B_WAIT, DONE.
- IDLE: entered only from reset; one cycle; stall=1; -> CAPTURE.
- CAPTURE:
  - Registers cpu_im_addr, cpu_dm_addr, wdata, wstrb, and dm_op (NONE/READ/WRITE); stall=1.
  - Access A = DM if DM_FIRST and dm_op≠NONE, else IM. Access B = the other one, if needed.
  - If dm_op=NONE, only the IM access runs (A=IM, B skipped). -> A_REQ.
- A_REQ / B_REQ:
  - mem_req_valid=1 with the captured fields; mem_req_addr={addr[31:2],2'b00}.
  - Fields stay stable until mem_req_ready=1; valid is never withdrawn. On ready -> matching _WAIT.
- A_WAIT / B_WAIT:
  - On mem_rsp_valid, load mem_rsp_data into im_rdata (IM read) or dm_rdata (DM read). A DM write only needs the ack; dm_rdata is unchanged.
  - A_WAIT -> B_REQ if B is needed, else -> DONE. B_WAIT -> DONE.
- DONE: stall=0 for exactly one cycle; CPU pipeline advances on this edge; -> CAPTURE.

Timing and counters:
- Minimum step length (one access, ready and response each in the cycle after issue): CAPTURE, REQ, WAIT, DONE = 4 cycles, i.e. stall low 1 of 4 cycles.
- stall is registered, a pure function of state; no combinational path from CPU inputs to stall.
- im_rdata / dm_rdata hold their value until the next completing read.
- stall_cnt increments every cycle stall=1 and saturates at all-ones.

Protocol checks (proto_err set, sticky until reset):
- cpu_dm_read and cpu_dm_write both high at CAPTURE: treated as WRITE.
- mem_rsp_valid in any state other than *_WAIT: response ignored.
- mem_rsp_valid in the same cycle as mem_req_ready is not a completion; completion needs rsp_valid while in *_WAIT.

Decomposition:
- Shared package `cpu_mem_pkg`: seq_state_e enum, dm_op_e {DM_NONE, DM_READ, DM_WRITE}, localparam WORD_MASK.
- One natural sub-module: `mem_req_issue`, which holds the request fields and drives valid/ready for a single outstanding request. The FSM, capture registers and counter live in the top.

Test Plan:
- Reset release, IM-only steps, mem ready/rsp one cycle after issue, rsp_data=0x00000013 -> stall low every 4th cycle; im_rdata=0x00000013 in DONE; mem_req_addr=cpu_im_addr&~3.
- Load, DM_FIRST=1, dm_addr=0x1006, rsp A=0xDEADBEEF then B=0x00A00093 -> first request addr 0x1004 write=0; dm_rdata=0xDEADBEEF, im_rdata=0x00A00093 in DONE; step = 6 cycles.
- Store, wstrb=4'b0011, wdata=0x1234ABCD, mem_req_ready held low 5 cycles -> valid and fields stable all 5 cycles; write ack completes; dm_rdata unchanged; stall_cnt grows by the full stall length.
- rst low in B_WAIT -> mem_req_valid=0, stall=1, counters=0 immediately; restart fetches from the new cpu_im_addr.
- Spurious mem_rsp_valid in CAPTURE, and read+write both high -> proto_err=1 and stays 1; data registers unchanged by the spurious rsp; the access runs as a write.
- DM_FIRST=0 load -> IM request issued before DM request; final outputs identical to the DM_FIRST=1 case.
